io_bus_responder: RTL

IO_BUS_RESPONDER -- requirements
Module: io_bus_responder

---
 rtl/io_bus_responder.sv | 81 ++++++++
 1 files changed

// File: rtl/io_bus_responder.sv
// io_bus_responder: IN/OUT I/O register block with GPIO, scratch and prescaled 8-bit timer.
module io_bus_responder #(
  parameter int DATA_WIDTH    = 8,
  parameter int IO_ADDR_WIDTH = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [IO_ADDR_WIDTH-1:0] io_addr,
  input  logic [DATA_WIDTH-1:0]    io_wdata,
  input  logic                     io_we,
  input  logic                     io_re,
  output logic [DATA_WIDTH-1:0]    io_rdata,
  output logic                     io_rvalid,
  input  logic [7:0]               gpio_in,
  output logic [7:0]               gpio_out,
  output logic [7:0]               gpio_oe,
  output logic                     irq
);
  localparam logic [IO_ADDR_WIDTH-1:0] A_PIN   = IO_ADDR_WIDTH'(3);
  localparam logic [IO_ADDR_WIDTH-1:0] A_DDR   = IO_ADDR_WIDTH'(4);
  localparam logic [IO_ADDR_WIDTH-1:0] A_PORT  = IO_ADDR_WIDTH'(5);
  localparam logic [IO_ADDR_WIDTH-1:0] A_SCR   = IO_ADDR_WIDTH'(6);
  localparam logic [IO_ADDR_WIDTH-1:0] A_TCNT  = IO_ADDR_WIDTH'(7);
  localparam logic [IO_ADDR_WIDTH-1:0] A_TCTRL = IO_ADDR_WIDTH'(8);
  logic [7:0] pin_s1, pin_s2, ddr, port, scratch, tcnt, presc, pmax, rd_mux;
  logic [7:0] tcnt_nxt, presc_nxt;
  logic [1:0] ps;
  logic       en, ie, ovf, ovf_nxt, tick, wr_tcnt, wr_tctrl;
  assign wr_tcnt  = io_we && io_addr == A_TCNT;
  assign wr_tctrl = io_we && io_addr == A_TCTRL;
  assign gpio_out = port;
  assign gpio_oe  = ddr;
  assign irq      = ovf & ie;
  always_comb begin
    pmax      = ps == 2'd0 ? 8'd0 : ps == 2'd1 ? 8'd7 : ps == 2'd2 ? 8'd63 : 8'd255;
    tick      = en && presc == pmax;
    presc_nxt = (!en || wr_tctrl || tick) ? 8'd0 : presc + 8'd1;
    tcnt_nxt  = wr_tcnt ? io_wdata[7:0] : tick ? tcnt + 8'd1 : tcnt;
    // a same-cycle overflow outranks a write-1-to-clear of OVF
    ovf_nxt   = (tick && tcnt == 8'hFF) ? 1'b1 : (wr_tctrl && io_wdata[7]) ? 1'b0 : ovf;
    rd_mux    = io_addr == A_PIN   ? pin_s2 :
                io_addr == A_DDR   ? ddr :
                io_addr == A_PORT  ? port :
                io_addr == A_SCR   ? scratch :
                io_addr == A_TCNT  ? tcnt :
                io_addr == A_TCTRL ? {ovf, ie, 3'b000, ps, en} : 8'h00;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pin_s1    <= '0;
      pin_s2    <= '0;
      ddr       <= '0;
      port      <= '0;
      scratch   <= '0;
      tcnt      <= '0;
      presc     <= '0;
      en        <= 1'b0;
      ps        <= '0;
      ie        <= 1'b0;
      ovf       <= 1'b0;
      io_rdata  <= '0;
      io_rvalid <= 1'b0;
    end else begin
      pin_s1    <= gpio_in;
      pin_s2    <= pin_s1;
      presc     <= presc_nxt;
      tcnt      <= tcnt_nxt;
      ovf       <= ovf_nxt;
      io_rvalid <= io_re;
      if (io_re) io_rdata <= DATA_WIDTH'(rd_mux);
      if (io_we && io_addr == A_DDR) ddr <= io_wdata[7:0];
      if (io_we && io_addr == A_PORT) port <= io_wdata[7:0];
      if (io_we && io_addr == A_SCR) scratch <= io_wdata[7:0];
      if (wr_tctrl) begin
        en <= io_wdata[0];
        ps <= io_wdata[2:1];
        ie <= io_wdata[6];
      end
    end
  end
endmodule
